// File: rtl/cronometro_bcd_pkg.sv
// Shared encodings for the two-digit BCD stopwatch: control FSM states and BCD limits.
package cronometro_bcd_pkg;

   localparam logic [1:0] ST_STOPPED = 2'd0;
   localparam logic [1:0] ST_RUNNING = 2'd1;
   localparam logic [1:0] ST_PAUSED  = 2'd2;

   localparam logic [3:0] BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      STOPPED = ST_STOPPED,
      RUNNING = ST_RUNNING,
      PAUSED  = ST_PAUSED
   } state_e;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: clear has priority over increment; the digit rolls to 0 after TERM.
module bcd_digit
   import cronometro_bcd_pkg::*;
#(
   parameter logic [3:0] TERM = BCD_MAX
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       inc_i,
   input  logic       clr_i,
   output logic [3:0] digit_o,
   output logic       wrap_o
);

   logic [3:0] digit_q, digit_d;

   // >= rather than == keeps the digit inside 0..TERM even from a corrupted value.
   always_comb begin
      digit_d = digit_q;
      if (clr_i) begin
         digit_d = '0;
      end else if (inc_i) begin
         digit_d = (digit_q >= TERM) ? 4'd0 : digit_q + 4'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         digit_q <= '0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit_o = digit_q;
   assign wrap_o  = (digit_q == TERM);

endmodule

// File: rtl/cronometro_bcd.sv
// Counts rising edges of the divider tick as a two-digit BCD value 00..MAX_COUNT,
// gated by a start/stop/clear FSM, with a one-cycle carry on wrap.
module cronometro_bcd
   import cronometro_bcd_pkg::*;
#(
   parameter int MAX_COUNT = 59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_in,
   input  logic       start,
   input  logic       stop,
   input  logic       clear,
   output logic [3:0] dig_uni,
   output logic [3:0] dig_dez,
   output logic       running,
   output logic       carry,
   output logic [1:0] state_dbg
);

   localparam logic [3:0] MAX_DEZ = 4'(MAX_COUNT / 10);
   localparam logic [3:0] MAX_UNI = 4'(MAX_COUNT % 10);

   generate
      if (MAX_COUNT < 1 || MAX_COUNT > 99) begin : g_bad_max
         $error("cronometro_bcd: MAX_COUNT must be within 1..99");
      end
   endgenerate

   state_e state_q, state_d;
   logic   tick_prev_q;
   logic   running_q;
   logic   carry_q;
   logic   tick_edge;
   logic   count;
   logic   at_max;
   logic   uni_wrap;
   logic   dez_at_term;
   logic   wrap_clr;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         STOPPED: if (start && !stop) state_d = RUNNING;
         RUNNING: if (stop) state_d = PAUSED;
         PAUSED: begin
            if (clear) begin
               state_d = STOPPED;
            end else if (start && !stop) begin
               state_d = RUNNING;
            end
         end
         default: state_d = STOPPED;
      endcase
   end

   // tick_prev resets high so a tick already high at reset release is not an edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= STOPPED;
         tick_prev_q <= 1'b1;
         running_q   <= 1'b0;
         carry_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_prev_q <= tick_in;
         running_q   <= (state_d == RUNNING);
         carry_q     <= count && at_max;
      end
   end

   assign tick_edge = tick_in && !tick_prev_q;
   assign count     = tick_edge && (state_q == RUNNING) && !clear;
   assign at_max    = dez_at_term && (dig_uni == MAX_UNI);
   assign wrap_clr  = clear || (count && at_max);

   bcd_digit #(.TERM(BCD_MAX)) u_uni (
      .clk_i   (clk),
      .rst_ni  (rst),
      .inc_i   (count),
      .clr_i   (wrap_clr),
      .digit_o (dig_uni),
      .wrap_o  (uni_wrap)
   );

   // Tens advance on a units roll-over, except on the terminal count where both clear.
   bcd_digit #(.TERM(MAX_DEZ)) u_dez (
      .clk_i   (clk),
      .rst_ni  (rst),
      .inc_i   (count && uni_wrap && !at_max),
      .clr_i   (wrap_clr),
      .digit_o (dig_dez),
      .wrap_o  (dez_at_term)
   );

   assign running   = running_q;
   assign carry     = carry_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_cronometro_bcd.sv
// Directed bench for cronometro_bcd: stimulus queues hand-computed expectations
// stamped with a cycle number, and a negedge monitor pops and compares them.
module tb_cronometro_bcd;
   import cronometro_bcd_pkg::*;

   logic       clk;
   logic       rst;
   logic       tick_in;
   logic       start;
   logic       stop;
   logic       clear;
   logic [3:0] dig_uni;
   logic [3:0] dig_dez;
   logic       running;
   logic       carry;
   logic [1:0] state_dbg;

   typedef struct packed {
      logic [31:0] cyc;
      logic [3:0]  uni;
      logic [3:0]  dez;
      logic        run;
      logic        car;
      logic [1:0]  st;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    cyc_n     = 0;
   int    tests_run = 0;
   int    tests_bad = 0;

   cronometro_bcd #(.MAX_COUNT(59)) dut (
      .clk       (clk),
      .rst       (rst),
      .tick_in   (tick_in),
      .start     (start),
      .stop      (stop),
      .clear     (clear),
      .dig_uni   (dig_uni),
      .dig_dez   (dig_dez),
      .running   (running),
      .carry     (carry),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc_n <= cyc_n + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of stimulus, want completion before 200000ns");
      $fatal(1, "watchdog expired");
   end

   // scoreboard helpers
   task automatic compare(input string nm, input exp_t e);
      tests_run++;
      if (dig_uni !== e.uni || dig_dez !== e.dez || running !== e.run ||
          carry !== e.car || state_dbg !== e.st) begin
         tests_bad++;
         $display("FAIL %s cyc=%0d: got uni=%0d dez=%0d run=%0b carry=%0b st=%0d, want uni=%0d dez=%0d run=%0b carry=%0b st=%0d",
                  nm, cyc_n, dig_uni, dig_dez, running, carry, state_dbg,
                  e.uni, e.dez, e.run, e.car, e.st);
      end
   endtask

   task automatic exp1(input int uni, input int dez, input bit run, input bit car,
                       input logic [1:0] st, input string nm);
      exp_t e;
      e.cyc = 32'(cyc_n + 1);
      e.uni = 4'(uni);
      e.dez = 4'(dez);
      e.run = run;
      e.car = car;
      e.st  = st;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // monitor
   always @(negedge clk) begin
      exp_t  e;
      string nm;
      while (exp_q.size() > 0 && int'(exp_q[0].cyc) <= cyc_n) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         if (int'(e.cyc) != cyc_n) begin
            tests_run++;
            tests_bad++;
            $display("FAIL %s: got check at cyc=%0d, want cyc=%0d", nm, cyc_n, e.cyc);
         end else begin
            compare(nm, e);
         end
      end
   end

   // driver tasks
   task automatic drive(input bit t, input bit s, input bit p, input bit c);
      tick_in = t;
      start   = s;
      stop    = p;
      clear   = c;
      @(negedge clk);
   endtask

   task automatic pulse(input int val, input bit run, input logic [1:0] st, input bit car,
                        input int low_cycles, input string nm);
      exp1(val % 10, val / 10, run, car, st, nm);
      drive(1, 0, 0, 0);
      for (int k = 0; k < low_cycles; k++) begin
         exp1(val % 10, val / 10, run, 1'b0, st, {nm, "_lo"});
         drive(0, 0, 0, 0);
      end
   endtask

   initial begin
      exp_t e;
      rst     = 1'b0;
      tick_in = 1'b1;
      start   = 1'b0;
      stop    = 1'b0;
      clear   = 1'b0;
      @(negedge clk);

      // reset while tick high, release, start: nothing counted
      exp1(0, 0, 0, 0, ST_STOPPED, "t1_reset");
      drive(1, 0, 0, 0);
      rst = 1'b1;
      exp1(0, 0, 0, 0, ST_STOPPED, "t1_release");
      drive(1, 0, 0, 0);
      exp1(0, 0, 1, 0, ST_RUNNING, "t1_start");
      drive(1, 1, 0, 0);
      exp1(0, 0, 1, 0, ST_RUNNING, "t1_hold");
      drive(1, 0, 0, 0);
      exp1(0, 0, 1, 0, ST_RUNNING, "t1_low");
      drive(0, 0, 0, 0);

      // 12 one-cycle ticks spaced 10 clk apart
      for (int i = 1; i <= 12; i++) pulse(i, 1, ST_RUNNING, 0, 9, "t2_count");

      // tick held high for 5 cycles: one increment (12 -> 13)
      for (int k = 0; k < 5; k++) begin
         exp1(3, 1, 1, 0, ST_RUNNING, "t4_held");
         drive(1, 0, 0, 0);
      end
      exp1(3, 1, 1, 0, ST_RUNNING, "t4_released");
      drive(0, 0, 0, 0);

      // clear while running, then 60 ticks: 59 then wrap to 00 with carry
      exp1(0, 0, 1, 0, ST_RUNNING, "t3_clear");
      drive(0, 0, 0, 1);
      for (int i = 1; i <= 60; i++) pulse(i % 60, 1, ST_RUNNING, i == 60, 1, "t3_wrap");

      // count to 07, stop with coincident tick is counted
      for (int i = 1; i <= 7; i++) pulse(i, 1, ST_RUNNING, 0, 1, "t5_count");
      exp1(8, 0, 0, 0, ST_PAUSED, "t5_stop_tick");
      drive(1, 0, 1, 0);
      exp1(8, 0, 0, 0, ST_PAUSED, "t5_paused");
      drive(0, 0, 0, 0);
      pulse(8, 0, ST_PAUSED, 0, 1, "t5_paused_tick");
      pulse(8, 0, ST_PAUSED, 0, 1, "t5_paused_tick");
      exp1(8, 0, 1, 0, ST_RUNNING, "t5_resume");
      drive(0, 1, 0, 0);
      exp1(0, 0, 1, 0, ST_RUNNING, "t5_clear_tick");
      drive(1, 0, 0, 1);
      exp1(0, 0, 1, 0, ST_RUNNING, "t5_after_clear");
      drive(0, 0, 0, 0);

      // start with coincident tick from PAUSED is not counted
      exp1(0, 0, 0, 0, ST_PAUSED, "t5_stop");
      drive(0, 0, 1, 0);
      exp1(0, 0, 1, 0, ST_RUNNING, "t5_start_tick");
      drive(1, 1, 0, 0);
      exp1(0, 0, 1, 0, ST_RUNNING, "t5_start_tick_lo");
      drive(0, 0, 0, 0);
      pulse(1, 1, ST_RUNNING, 0, 1, "t5_first_after_start");

      // clear beats start in PAUSED; stop beats start in STOPPED
      exp1(1, 0, 0, 0, ST_PAUSED, "t5_stop2");
      drive(0, 0, 1, 0);
      exp1(0, 0, 0, 0, ST_STOPPED, "t5_clear_beats_start");
      drive(0, 1, 0, 1);
      exp1(0, 0, 0, 0, ST_STOPPED, "t5_stop_beats_start");
      drive(0, 1, 1, 0);
      pulse(0, 0, ST_STOPPED, 0, 1, "t5_stopped_tick");
      exp1(0, 0, 1, 0, ST_RUNNING, "t6_start");
      drive(0, 1, 0, 0);

      // count to 33, then asynchronous reset mid-cycle
      for (int i = 1; i <= 33; i++) pulse(i, 1, ST_RUNNING, 0, 1, "t6_count");
      #2 rst = 1'b0;
      #1;
      e.cyc = 32'(cyc_n);
      e.uni = 4'd0;
      e.dez = 4'd0;
      e.run = 1'b0;
      e.car = 1'b0;
      e.st  = ST_STOPPED;
      compare("t6_async_reset", e);
      @(negedge clk);
      exp1(0, 0, 0, 0, ST_STOPPED, "t6_in_reset");
      drive(1, 0, 0, 0);
      rst = 1'b1;
      pulse(0, 0, ST_STOPPED, 0, 1, "t6_ignored_tick");
      pulse(0, 0, ST_STOPPED, 0, 1, "t6_ignored_tick");
      exp1(0, 0, 1, 0, ST_RUNNING, "t6_restart");
      drive(0, 1, 0, 0);
      pulse(1, 1, ST_RUNNING, 0, 1, "t6_count_after");

      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);

      // final report
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         tests_run++;
         tests_bad++;
         $display("FAIL %s: got unchecked entry for cyc=%0d, want checked by cyc=%0d",
                  name_q.pop_front(), e.cyc, cyc_n);
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_bad);
      $finish;
   end

endmodule
